// File: rtl/coherence_pkg.sv
// ============================================================================
// Module : coherence_pkg
// Brief  : Shared cache-coherence constants and types for the victim selector.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package coherence_pkg;

  localparam logic [2:0] c_state_invalid = 3'b100;
  localparam int         WAYS            = 4;
  localparam int         PLRU_WIDTH      = 3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } sel_state_t;

endpackage

`default_nettype wire

// File: rtl/plru_tree.sv
// ============================================================================
// Module : plru_tree
// Brief  : 4-way tree-PLRU victim decode and post-access bit update.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module plru_tree
  import coherence_pkg::*;
(
  input  logic [PLRU_WIDTH-1:0] i_bits,
  input  logic [1:0]            i_way,
  output logic [1:0]            o_victim,
  output logic [PLRU_WIDTH-1:0] o_next_bits
);

  // bits are {b2,b1,b0}: b0 picks the pair, b1/b2 pick within the pair
  always_comb begin
    if (!i_bits[0]) begin
      o_victim = {1'b0, i_bits[1]};
    end else begin
      o_victim = {1'b1, i_bits[2]};
    end
  end

  always_comb begin
    o_next_bits = i_bits;
    if (!i_way[1]) begin
      o_next_bits[0] = 1'b1;
      o_next_bits[1] = ~i_way[0];
    end else begin
      o_next_bits[0] = 1'b0;
      o_next_bits[2] = ~i_way[0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/plru_victim_sel.sv
// ============================================================================
// Module : plru_victim_sel
// Brief  : Per-set tree-PLRU storage with hit/free/victim way selection.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module plru_victim_sel #(
  parameter int IDX_WIDTH = 6,
  parameter int WAYS      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [IDX_WIDTH-1:0] req_index,
  input  logic                 req_hit,
  input  logic [1:0]           req_hit_way,
  input  logic                 req_full,
  input  logic [WAYS-1:0]      req_valid_ways,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_way,
  output logic                 rsp_evict,
  input  logic                 plru_clr
);
  import coherence_pkg::*;

  localparam int c_sets = 2 ** IDX_WIDTH;

  sel_state_t                  r_state;
  logic                        r_req_ready;
  logic                        r_rsp_valid;
  logic [1:0]                  r_way;
  logic                        r_evict;
  logic [IDX_WIDTH-1:0]        r_idx;
  logic [PLRU_WIDTH-1:0]       r_plru [c_sets];

  logic [PLRU_WIDTH-1:0]       w_tree_bits;
  logic [1:0]                  w_victim;
  logic [PLRU_WIDTH-1:0]       w_next_bits;
  logic                        w_has_free;
  logic [1:0]                  w_free_way;
  logic [1:0]                  w_sel_way;
  logic                        w_sel_evict;
  logic                        w_handshake;

  // One tree serves both phases: victim lookup in IDLE, bit update in RESP
  assign w_tree_bits = (r_state == ST_IDLE) ? r_plru[req_index] : r_plru[r_idx];

  plru_tree u_plru_tree (
    .i_bits      (w_tree_bits),
    .i_way       (r_way),
    .o_victim    (w_victim),
    .o_next_bits (w_next_bits)
  );

  always_comb begin
    w_has_free = 1'b0;
    w_free_way = 2'd0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!req_valid_ways[i]) begin
        w_has_free = 1'b1;
        w_free_way = 2'(i);
      end
    end
  end

  // A "not full" miss with no free way falls back to the PLRU victim
  always_comb begin
    if (req_hit) begin
      w_sel_way   = req_hit_way;
      w_sel_evict = 1'b0;
    end else if (!req_full && w_has_free) begin
      w_sel_way   = w_free_way;
      w_sel_evict = 1'b0;
    end else begin
      w_sel_way   = w_victim;
      w_sel_evict = 1'b1;
    end
  end

  assign w_handshake = (r_state == ST_RESP) && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_way       <= 2'd0;
      r_evict     <= 1'b0;
      r_idx       <= '0;
      for (int s = 0; s < c_sets; s++) begin
        r_plru[s] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_state     <= ST_RESP;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_way       <= w_sel_way;
            r_evict     <= w_sel_evict;
            r_idx       <= req_index;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase

      if (plru_clr) begin
        for (int s = 0; s < c_sets; s++) begin
          r_plru[s] <= '0;
        end
      end else if (w_handshake) begin
        r_plru[r_idx] <= w_next_bits;
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_way   = r_way;
  assign rsp_evict = r_evict;

endmodule

`default_nettype wire

// File: tb/tb_plru_victim_sel.sv
// ============================================================================
// Module : tb_plru_victim_sel
// Brief  : Table-driven scoreboard bench for plru_victim_sel.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_plru_victim_sel;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_index;
  logic       req_hit;
  logic [1:0] req_hit_way;
  logic       req_full;
  logic [3:0] req_valid_ways;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_way;
  logic       rsp_evict;
  logic       plru_clr;

  int n_cmp;
  int n_err;

  typedef struct {
    logic [5:0] idx;
    logic       hit;
    logic [1:0] hw;
    logic       full;
    logic [3:0] vw;
    logic [1:0] ew;
    logic       ee;
  } vec_t;

  vec_t       tbl [18];
  logic [2:0] exp_q [$];

  plru_victim_sel #(
    .IDX_WIDTH (6),
    .WAYS      (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_index      (req_index),
    .req_hit        (req_hit),
    .req_hit_way    (req_hit_way),
    .req_full       (req_full),
    .req_valid_ways (req_valid_ways),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_way        (rsp_way),
    .rsp_evict      (rsp_evict),
    .plru_clr       (plru_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, need done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_req(input vec_t v);
    int k;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid      = 1'b1;
    req_index      = v.idx;
    req_hit        = v.hit;
    req_hit_way    = v.hw;
    req_full       = v.full;
    req_valid_ways = v.vw;
    exp_q.push_back({v.ee, v.ew});
  endtask

  // Issue one request, optionally stall the response and pulse plru_clr at the handshake
  task automatic send(input vec_t v, input int hold, input logic clr);
    logic [2:0] e;
    drive_req(v);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rsp_valid_latency", 32'(rsp_valid), 32'd1);
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    e = exp_q.pop_front();
    chk("rsp_way", 32'(rsp_way), 32'(e[1:0]));
    chk("rsp_evict", 32'(rsp_evict), 32'(e[2]));
    if (hold > 0) begin
      rsp_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("hold_req_ready", 32'(req_ready), 32'd0);
        chk("hold_rsp_way", 32'(rsp_way), 32'(e[1:0]));
        chk("hold_rsp_evict", 32'(rsp_evict), 32'(e[2]));
      end
      rsp_ready = 1'b1;
    end
    plru_clr = clr;
    @(negedge clk);
    plru_clr = 1'b0;
    chk("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
  endtask

  function automatic vec_t fm(input logic [5:0] idx, input logic [1:0] ew);
    vec_t v;
    v = '{idx, 1'b0, 2'd0, 1'b1, 4'hF, ew, 1'b1};
    return v;
  endfunction

  initial begin
    logic [2:0] e;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    req_valid = 1'b0;
    req_index = '0;
    req_hit = 1'b0;
    req_hit_way = 2'd0;
    req_full = 1'b0;
    req_valid_ways = 4'h0;
    rsp_ready = 1'b1;
    plru_clr = 1'b0;

    tbl[0]  = fm(6'd5, 2'd0);
    tbl[1]  = fm(6'd5, 2'd2);
    tbl[2]  = fm(6'd5, 2'd1);
    tbl[3]  = fm(6'd5, 2'd3);
    tbl[4]  = fm(6'd5, 2'd0);
    tbl[5]  = '{6'd7,  1'b0, 2'd0, 1'b0, 4'b1011, 2'd2, 1'b0};
    tbl[6]  = fm(6'd7, 2'd0);
    tbl[7]  = '{6'd9,  1'b1, 2'd3, 1'b1, 4'b1111, 2'd3, 1'b0};
    tbl[8]  = fm(6'd9, 2'd0);
    tbl[9]  = fm(6'd10, 2'd0);
    tbl[10] = '{6'd12, 1'b1, 2'd1, 1'b1, 4'b1111, 2'd1, 1'b0};
    tbl[11] = fm(6'd12, 2'd2);
    tbl[12] = '{6'd13, 1'b0, 2'd0, 1'b0, 4'b1111, 2'd0, 1'b1};
    tbl[13] = '{6'd14, 1'b1, 2'd2, 1'b0, 4'b0000, 2'd2, 1'b0};
    tbl[14] = '{6'd15, 1'b0, 2'd0, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[15] = '{6'd16, 1'b0, 2'd0, 1'b0, 4'b1110, 2'd0, 1'b0};
    tbl[16] = '{6'd17, 1'b0, 2'd0, 1'b0, 4'b0111, 2'd3, 1'b0};
    tbl[17] = fm(6'd63, 2'd0);

    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_way", 32'(rsp_way), 32'd0);
    chk("reset_rsp_evict", 32'(rsp_evict), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      send(tbl[i], 0, 1'b0);
    end

    // Stalled response with a coincident clear: set 20 and set 5 must both restart at way0
    send(fm(6'd20, 2'd0), 0, 1'b0);
    send(fm(6'd20, 2'd2), 3, 1'b1);
    send(fm(6'd20, 2'd0), 0, 1'b0);
    send(fm(6'd5, 2'd0), 0, 1'b0);

    // Reset while a response is pending
    send(fm(6'd30, 2'd0), 0, 1'b0);
    drive_req(fm(6'd30, 2'd2));
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    e = exp_q.pop_front();
    chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("pre_rst_rsp_way", 32'(rsp_way), 32'(e[1:0]));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_rst_req_ready", 32'(req_ready), 32'd1);
    chk("async_rst_rsp_way", 32'(rsp_way), 32'd0);
    chk("async_rst_rsp_evict", 32'(rsp_evict), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    send(fm(6'd30, 2'd0), 0, 1'b0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
